// File: rtl/keypad_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : keypad_scan_ctrl
//  Function : 4x4 matrix keypad scanner with debounce, one-deep key holding
//             register with a valid/ready handshake, and a sticky overflow flag.
//             Macro KEYPAD_SYNC_EN adds a 2-flop synchronizer on row_i.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic [3:0] key_code_o,
    output logic       key_valid_o,
    input  logic       key_ready_i,
    output logic       ovf_o,
    input  logic       ovf_clr_i
);

    localparam int c_DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_DEB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_RELEASE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_col_idx;
    logic [1:0]         w_col_nxt;
    logic [1:0]         r_row_idx;
    logic [1:0]         w_row_nxt;
    logic [c_DIV_W-1:0] r_div_cnt;
    logic [c_DIV_W-1:0] w_div_nxt;
    logic [c_DEB_W-1:0] r_deb_cnt;
    logic [c_DEB_W-1:0] w_deb_nxt;
    logic [3:0]         r_key_code;
    logic [3:0]         w_code_nxt;
    logic               r_key_valid;
    logic               w_valid_nxt;
    logic               r_ovf;
    logic               w_ovf_nxt;
    logic               w_emit;

    logic [3:0]         w_rows;
    logic               w_any_low;
    logic [1:0]         w_low_idx;
    logic               w_latched_low;

`ifdef KEYPAD_SYNC_EN
    logic [3:0] r_row_meta;
    logic [3:0] r_row_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= row_i;
            r_row_sync <= r_row_meta;
        end
    end

    assign w_rows = r_row_sync;
`else
    assign w_rows = row_i;
`endif

    // Lowest-numbered active row takes priority when several are pressed.
    always_comb begin
        w_any_low = ~&w_rows;
        w_low_idx = 2'd3;
        if (!w_rows[0]) begin
            w_low_idx = 2'd0;
        end else if (!w_rows[1]) begin
            w_low_idx = 2'd1;
        end else if (!w_rows[2]) begin
            w_low_idx = 2'd2;
        end
    end

    assign w_latched_low = ~w_rows[r_row_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_SCAN;
            r_col_idx   <= 2'd0;
            r_row_idx   <= 2'd0;
            r_div_cnt   <= '0;
            r_deb_cnt   <= '0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_col_idx   <= w_col_nxt;
            r_row_idx   <= w_row_nxt;
            r_div_cnt   <= w_div_nxt;
            r_deb_cnt   <= w_deb_nxt;
            r_key_code  <= w_code_nxt;
            r_key_valid <= w_valid_nxt;
            r_ovf       <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col_idx;
        w_row_nxt   = r_row_idx;
        w_div_nxt   = r_div_cnt;
        w_deb_nxt   = r_deb_cnt;
        w_emit      = 1'b0;

        case (r_state)
            ST_SCAN: begin
                if (r_div_cnt == c_DIV_LAST) begin
                    w_div_nxt = '0;
                    if (w_any_low) begin
                        w_row_nxt   = w_low_idx;
                        w_deb_nxt   = '0;
                        w_state_nxt = ST_DEBOUNCE;
                    end else begin
                        w_col_nxt = r_col_idx + 2'd1;
                    end
                end else begin
                    w_div_nxt = r_div_cnt + 1'b1;
                end
            end

            ST_DEBOUNCE: begin
                if (!w_latched_low) begin
                    // Bounce: rescan the same column from a fresh dwell.
                    w_div_nxt   = '0;
                    w_deb_nxt   = '0;
                    w_state_nxt = ST_SCAN;
                end else if (r_deb_cnt == c_DEB_LAST) begin
                    w_emit      = 1'b1;
                    w_deb_nxt   = '0;
                    w_state_nxt = ST_RELEASE;
                end else begin
                    w_deb_nxt = r_deb_cnt + 1'b1;
                end
            end

            ST_RELEASE: begin
                if (w_any_low) begin
                    w_deb_nxt = '0;
                end else if (r_deb_cnt == c_DEB_LAST) begin
                    w_deb_nxt   = '0;
                    w_div_nxt   = '0;
                    w_col_nxt   = r_col_idx + 2'd1;
                    w_state_nxt = ST_SCAN;
                end else begin
                    w_deb_nxt = r_deb_cnt + 1'b1;
                end
            end

            default: begin
                w_div_nxt   = '0;
                w_deb_nxt   = '0;
                w_state_nxt = ST_SCAN;
            end
        endcase
    end

    // Consumption and a new emit can coincide; the emit reload wins.
    always_comb begin
        w_code_nxt  = r_key_code;
        w_valid_nxt = r_key_valid & ~key_ready_i;
        w_ovf_nxt   = r_ovf & ~ovf_clr_i;
        if (w_emit) begin
            if (!r_key_valid || key_ready_i) begin
                w_code_nxt  = {r_col_idx, r_row_idx};
                w_valid_nxt = 1'b1;
            end else begin
                w_ovf_nxt = 1'b1;
            end
        end
    end

    assign col_o       = ~(4'b0001 << r_col_idx);
    assign key_code_o  = r_key_code;
    assign key_valid_o = r_key_valid;
    assign ovf_o       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_scan_ctrl
//  Function : Directed self-checking bench for keypad_scan_ctrl with a
//             behavioural 4x4 key matrix (SCAN_DIV=4, DEBOUNCE_CYC=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row_i;
    logic [3:0]  col_o;
    logic [3:0]  key_code_o;
    logic        key_valid_o;
    logic        key_ready_i;
    logic        ovf_o;
    logic        ovf_clr_i;

    logic [15:0] keys;
    logic        vpre;
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CYC (8)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row_i       (row_i),
        .col_o       (col_o),
        .key_code_o  (key_code_o),
        .key_valid_o (key_valid_o),
        .key_ready_i (key_ready_i),
        .ovf_o       (ovf_o),
        .ovf_clr_i   (ovf_clr_i)
    );

    // Key at bit col*4+row pulls its row low while its column is driven low.
    always_comb begin
        row_i = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (keys[c*4+r] && !col_o[c]) begin
                    row_i[r] = 1'b0;
                end
            end
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_col_entry(input logic [3:0] col_pat);
        logic [3:0] prev;
        bit         hit;
        hit = 1'b0;
        for (int i = 0; i < 64 && !hit; i++) begin
            prev = col_o;
            step(1);
            if (col_o == col_pat && prev != col_pat) hit = 1'b1;
        end
        chk_eq("col_entry", {31'd0, hit}, 32'd1);
    endtask

    // Press at column entry; returns just after the emit edge (entry + 12).
    task automatic press_until_emit(input logic [15:0] mask, input logic [3:0] col_pat,
                                    input bit rdy, input bit clr, output logic valid_pre);
        wait_col_entry(col_pat);
        keys = mask;
        step(11);
        valid_pre   = key_valid_o;
        key_ready_i = rdy;
        ovf_clr_i   = clr;
        step(1);
        key_ready_i = 1'b0;
        ovf_clr_i   = 1'b0;
    endtask

    task automatic release_keys();
        keys = 16'h0000;
        step(8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b1;
        keys        = 16'h0000;
        key_ready_i = 1'b0;
        ovf_clr_i   = 1'b0;
        #1 rst_n    = 1'b0;
        #2;
        chk_eq("rst_col", col_o, 4'b1110);
        chk_eq("rst_valid", key_valid_o, 1'b0);
        chk_eq("rst_code", key_code_o, 4'h0);
        chk_eq("rst_ovf", ovf_o, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic press on column 2, row 1
        press_until_emit(16'h0200, 4'b1011, 1'b0, 1'b0, vpre);
        chk_eq("k9_valid_pre", vpre, 1'b0);
        chk_eq("k9_valid", key_valid_o, 1'b1);
        chk_eq("k9_code", key_code_o, 4'h9);
        chk_eq("k9_ovf", ovf_o, 1'b0);
        step(5);
        chk_eq("k9_hold_col", col_o, 4'b1011);
        keys = 16'h0000;
        step(7);
        chk_eq("k9_release_col", col_o, 4'b1011);
        chk_eq("k9_valid_stable", key_valid_o, 1'b1);
        step(1);
        chk_eq("k9_next_col", col_o, 4'b0111);
        key_ready_i = 1'b1;
        step(1);
        key_ready_i = 1'b0;
        chk_eq("k9_consumed", key_valid_o, 1'b0);
        key_ready_i = 1'b1;
        step(2);
        key_ready_i = 1'b0;
        chk_eq("idle_ready_valid", key_valid_o, 1'b0);
        chk_eq("idle_ready_code", key_code_o, 4'h9);

        // Bounce on column 3, row 0: low for 3 cycles only
        wait_col_entry(4'b0111);
        step(3);
        keys = 16'h1000;
        step(3);
        chk_eq("bounce_frozen", col_o, 4'b0111);
        keys = 16'h0000;
        step(4);
        chk_eq("bounce_same_col", col_o, 4'b0111);
        step(1);
        chk_eq("bounce_advance", col_o, 4'b1110);
        chk_eq("bounce_valid", key_valid_o, 1'b0);

        // Overflow: two keys without consumption
        press_until_emit(16'h0004, 4'b1110, 1'b0, 1'b0, vpre);
        chk_eq("k2_code", key_code_o, 4'h2);
        release_keys();
        press_until_emit(16'h0040, 4'b1101, 1'b0, 1'b0, vpre);
        chk_eq("ovf_set", ovf_o, 1'b1);
        chk_eq("ovf_keep_code", key_code_o, 4'h2);
        chk_eq("ovf_keep_valid", key_valid_o, 1'b1);
        release_keys();
        ovf_clr_i = 1'b1;
        step(1);
        ovf_clr_i = 1'b0;
        chk_eq("ovf_clr", ovf_o, 1'b0);
        press_until_emit(16'h0100, 4'b1011, 1'b0, 1'b1, vpre);
        chk_eq("ovf_clr_collide", ovf_o, 1'b1);
        chk_eq("ovf_collide_code", key_code_o, 4'h2);
        release_keys();
        ovf_clr_i = 1'b1;
        step(1);
        ovf_clr_i = 1'b0;
        chk_eq("ovf_clr2", ovf_o, 1'b0);

        // Consume and reload in the same emit cycle
        press_until_emit(16'h0080, 4'b1101, 1'b1, 1'b0, vpre);
        chk_eq("reload_valid_pre", vpre, 1'b1);
        chk_eq("reload_valid", key_valid_o, 1'b1);
        chk_eq("reload_code", key_code_o, 4'h7);
        chk_eq("reload_ovf", ovf_o, 1'b0);
        release_keys();
        key_ready_i = 1'b1;
        step(1);
        key_ready_i = 1'b0;
        chk_eq("reload_consumed", key_valid_o, 1'b0);

        // Rows 3 and 1 together on column 3
        press_until_emit(16'hA000, 4'b0111, 1'b0, 1'b0, vpre);
        chk_eq("multi_valid", key_valid_o, 1'b1);
        chk_eq("multi_code", key_code_o, 4'hD);
        release_keys();

        // Reset in the middle of DEBOUNCE
        wait_col_entry(4'b1110);
        keys = 16'h0002;
        step(7);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("mid_rst_col", col_o, 4'b1110);
        chk_eq("mid_rst_valid", key_valid_o, 1'b0);
        chk_eq("mid_rst_code", key_code_o, 4'h0);
        chk_eq("mid_rst_ovf", ovf_o, 1'b0);
        keys = 16'h0000;
        step(2);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_eq("post_rst_col", col_o, 4'b1110);
        step(4);
        chk_eq("post_rst_col1", col_o, 4'b1101);
        step(36);
        chk_eq("post_rst_valid", key_valid_o, 1'b0);
        chk_eq("post_rst_code", key_code_o, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameters: SCAN_DIV, default 1000, clk cycles each column is driven before its rows are sampled (min 1).
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 20000, clk cycles a press or release must stay stable (min 1).
REQ-003 SHALL have one clock, clk; reset is rst_n, asynchronous and active-low.
REQ-004 SHALL have ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- row_i  in  4  raw keypad rows, active-low, asynchronous to clk
- col_o  out  4  column drive, one-hot-low
- key_code_o  out  4  key code = col_idx*4 + row_idx
- key_valid_o  out  1  key_code_o holds an unconsumed key
- key_ready_i  in  1  consumer accepts key when high with key_valid_o
- ovf_o  out  1  sticky: a debounced key was dropped
- ovf_clr_i  in  1  clears ovf_o

Function
REQ-005 SHALL run FSM states SCAN, DEBOUNCE, RELEASE.
REQ-006 SCAN:
- drives col_o low on column col_idx for SCAN_DIV cycles.
- samples rows on the last dwell cycle.
- if any row is low, latches col_idx and row_idx (lowest-index low row wins) and enters DEBOUNCE with col_o frozen.
- otherwise advances col_idx, wrapping 3 to 0.
REQ-007 DEBOUNCE:
- counts cycles in which the latched row is low.
- if the latched row reads high on any cycle, returns to SCAN on the same column with the dwell counter cleared.
- after DEBOUNCE_CYC consecutive matching cycles, emits the key and enters RELEASE.
- key_valid_o rises exactly DEBOUNCE_CYC cycles after DEBOUNCE entry.
REQ-008 RELEASE SHALL hold col_o until all rows are high for DEBOUNCE_CYC consecutive cycles (any low row restarts the count), then enter SCAN on the next column.
REQ-009 Emit: if key_valid_o is 0, or key_ready_i is 1 in the emit cycle, SHALL load key_code_o and set key_valid_o. Otherwise SHALL keep the old code and set ovf_o.
REQ-010 key_valid_o and key_code_o SHALL stay stable until key_ready_i=1 while valid; key_valid_o clears on the next edge unless REQ-009 reloads it the same cycle.
REQ-011 ovf_clr_i SHALL clear ovf_o on the next edge; a simultaneous overflow event SHALL win (ovf_o stays 1).
REQ-012 Counter widths SHALL be $clog2 of their parameter, with no wrap or overflow at the maximum count.
REQ-013 key_ready_i while key_valid_o=0 SHALL have no effect.

Reset
REQ-014 rst_n low SHALL immediately force:
- state SCAN, col_idx 0, col_o 4'b1110
- all counters 0
- key_code_o 0, key_valid_o 0, ovf_o 0
REQ-015 Reset asserted mid-DEBOUNCE or mid-RELEASE SHALL discard the pending key; scanning restarts at column 0 after release.

Configuration
REQ-016 Macro KEYPAD_SYNC_EN:
- defined: row_i passes through a 2-flop synchronizer (reset to 4'hF) before all FSM use, adding 2 cycles to all latencies.
- undefined: row_i is used directly; the environment guarantees synchronous inputs.

Verification (SCAN_DIV=4, DEBOUNCE_CYC=8, KEYPAD_SYNC_EN undefined)
REQ-017 Row 1 held low while col_o=4'b1011 (col 2), key_ready_i=0 -> key_code_o=4'h9, key_valid_o=1 exactly 8 cycles after DEBOUNCE entry; col_o stays 4'b1011 until release plus 8 high cycles.
REQ-018 Row 0 low for 3 cycles then high (bounce) -> key_valid_o stays 0; scan resumes on the same column, then advances.
REQ-019 Two keys debounced with key_ready_i=0 throughout -> ovf_o=1, key_code_o keeps the first code; ovf_clr_i pulse -> ovf_o=0.
REQ-020 key_ready_i=1 in the same cycle a second key emits -> key_valid_o stays 1, new code loaded, ovf_o=0.
REQ-021 Rows 3 and 1 low together -> row_idx=1 reported.
REQ-022 rst_n pulsed low mid-DEBOUNCE -> outputs at reset values immediately; no key reported for that press.
